heart_emulator: RTL and testbench
=================================

# heart_emulator

- Synthetic heart model that drives the pacemaker's sense input and responds to its pacing output; it is the other end of the heartbeat/pace interface.
- Emits intrinsic beat pulses at a programmable interval.
- Can suppress every Nth beat to create pauses the pacemaker must fill.
- Treats a pace pulse as capture: it restarts the cardiac cycle and enters refractory.
- Sits beside the pacemaker core inside the top-level tile, so on-chip demos and self-test run without external stimulus.

## Interface
Parameters:
- RATE_W, 8, width of interval and tick counters
- PULSE_CYCLES, 4, beat_out high time in clk cycles (≥1)
- REFRACT_TICKS, 3, refractory length in ticks (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle timebase strobe (e.g. 1 ms)
- interval  in  RATE_W  intrinsic beat interval in ticks; 0 treated as 1
- drop_en  in  1  enable beat dropout
- drop_every  in  4  suppress every Nth due beat; 0 or 1 behave as 2
- pace_in  in  1  pacing pulse from pacemaker, level, rising edge significant
- beat_out  out  1  intrinsic beat pulse to pacemaker sense input
- capture  out  1  one-cycle strobe on accepted pace
- dropped  out  1  one-cycle strobe on suppressed beat
- beat_count  out  8  beat_out pulses issued, wraps
- pace_count  out  8  captures, wraps

## Operation
- States: FILL, BEAT, REFRACT.
- FILL:
  - tcnt cleared on entry; increments on each tick.
  - On a tick where tcnt+1 == max(interval,1) the beat is due.
  - interval is sampled every cycle; a change takes effect at the next compare.
- Beat due:
  - dcnt increments.
  - If drop_en and dcnt reaches the effective N: dcnt clears, dropped pulses, state re-enters FILL (tcnt=0), and beat_out stays low.
  - Otherwise the state goes to BEAT and beat_count increments.
  - dcnt is held at 0 while drop_en=0.
- BEAT: beat_out=1 for exactly PULSE_CYCLES clk cycles, then REFRACT.
- REFRACT: lasts REFRACT_TICKS ticks, then FILL.
- Pace handling:
  - Pace edge = pace_in high while the registered pace_in is low.
  - Pace edge in FILL: capture pulses, pace_count increments, state goes to REFRACT, and the tcnt progress is discarded.
  - Pace edges in BEAT or REFRACT are ignored: no capture and no count.
- Simultaneous pace edge and beat-due tick in FILL: pace wins. Capture is taken; no beat, no dropped pulse, dcnt unchanged.
- Reset state:
  - FILL, tcnt=0, dcnt=0.
  - beat_out, capture, dropped = 0.
  - beat_count, pace_count = 0.
  - Registered pace_in = 0, so pace_in already high at reset release counts as an edge on the first cycle.

## Timing
- All outputs are registered.
- beat_out rises 1 cycle after the cycle carrying the due tick.
- capture rises 1 cycle after the cycle in which pace_in first samples high.
- dropped rises 1 cycle after the due tick.
- Counter updates are visible in the same cycle as the corresponding strobe.
- Beat-to-beat period with no pacing and no dropout:
  - interval ticks plus BEAT time plus REFRACT_TICKS ticks.
  - BEAT time is PULSE_CYCLES cycles and is not tick-aligned.
- Ticks arriving during BEAT are not counted.
- Asynchronous rst mid-pulse clears beat_out immediately, with no glitch extension.

## Structure
- Shared package pacer_pkg holds:
  - The state enum (FILL, BEAT, REFRACT).
  - Default RATE_W.
  - The count width constant (8).
- The pacemaker core imports the same package.
- One sub-module: heart_tick_timer, a tick-gated up-counter with clear and terminal compare. It is instantiated once and shared between FILL (compare to interval) and REFRACT (compare to REFRACT_TICKS).

## Test plan
- interval=10, tick every 4 clk, drop_en=0, no pace:
  - beat_out pulses 4 cycles wide.
  - Beat-to-beat spacing is (10+3) ticks + 4 clk.
  - beat_count = 5 after 5 beats.
- drop_en=1, drop_every=3:
  - Beats 1,2 emitted, beat 3 suppressed with dropped=1 and beat_count unchanged.
  - Next beat follows after one interval + refractory.
- Pace edge 5 ticks into FILL (interval=10):
  - capture high 1 cycle, pace_count=1, no beat_out.
  - Next beat appears 3+10 ticks later.
- Pace edge on the same cycle as the due tick: capture=1, beat_out stays 0, dropped stays 0.
- Pace held high through BEAT, released, then re-asserted in REFRACT: no capture at either point; pace_count=0.
- rst asserted during BEAT's 2nd cycle:
  - beat_out=0 immediately and counts=0.
  - After release the first beat arrives interval ticks later; interval=0 gives a beat every tick-plus-pulse-plus-refractory cycle.

Source files
------------

// File: rtl/pacer_pkg.sv
// Types and constants shared by the pacemaker core and the synthetic heart model.
package pacer_pkg;

    localparam int RATE_W_DEFAULT = 8;
    localparam int COUNT_W        = 8;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        BEAT    = 2'd1,
        REFRACT = 2'd2
    } pacer_state_t;

endpackage

// File: rtl/heart_tick_timer.sv
// Tick-gated up-counter with synchronous clear and a terminal-count compare.
module heart_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] tcnt;
    logic [W:0]   tcnt_inc;

    assign tcnt_inc = {1'b0, tcnt} + (W+1)'(1);

    // >= rather than == so a terminal lowered below the running count fires
    // on the next tick instead of waiting for the counter to wrap.
    assign done = tick && (tcnt_inc >= {1'b0, term});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (clr) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= tcnt_inc[W-1:0];
        end
    end

endmodule

// File: rtl/heart_emulator.sv
// Synthetic heart: intrinsic beats at a programmable interval, optional beat
// dropout, and capture of pacing pulses that restart the cardiac cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FILL    | counting ticks toward the next intrinsic beat; pace accepted
//   BEAT    | beat_out high for PULSE_CYCLES clocks; ticks and pace ignored
//   REFRACT | counting REFRACT_TICKS ticks; pace ignored
module heart_emulator import pacer_pkg::*; #(
    parameter int RATE_W        = RATE_W_DEFAULT,
    parameter int PULSE_CYCLES  = 4,
    parameter int REFRACT_TICKS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [RATE_W-1:0]  interval,
    input  logic               drop_en,
    input  logic [3:0]         drop_every,
    input  logic               pace_in,
    output logic               beat_out,
    output logic               capture,
    output logic               dropped,
    output logic [COUNT_W-1:0] beat_count,
    output logic [COUNT_W-1:0] pace_count
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);

    pacer_state_t      state, state_nx;
    logic              pace_q;
    logic              pace_edge;
    logic [3:0]        dcnt, dcnt_nx;
    logic [3:0]        eff_n;
    logic [PW-1:0]     pcnt;
    logic [RATE_W-1:0] eff_interval;
    logic [RATE_W-1:0] term;
    logic              tmr_clr;
    logic              tmr_done;
    logic              cap_nx;
    logic              drop_nx;
    logic              beat_start;

    assign pace_edge    = pace_in && !pace_q;
    assign eff_interval = (interval == '0) ? RATE_W'(1) : interval;
    assign eff_n        = (drop_every < 4'd2) ? 4'd2 : drop_every;

    heart_tick_timer #(.W(RATE_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .tick (tick),
        .term (term),
        .done (tmr_done)
    );

    always_comb begin
        state_nx   = state;
        dcnt_nx    = dcnt;
        tmr_clr    = 1'b0;
        cap_nx     = 1'b0;
        drop_nx    = 1'b0;
        beat_start = 1'b0;
        term       = eff_interval;
        case (state)
            FILL: begin
                // Pace wins over a coincident due tick and leaves dcnt alone.
                if (pace_edge) begin
                    cap_nx   = 1'b1;
                    state_nx = REFRACT;
                    tmr_clr  = 1'b1;
                end else if (tmr_done) begin
                    tmr_clr = 1'b1;
                    if (drop_en && (({1'b0, dcnt} + 5'd1) >= {1'b0, eff_n})) begin
                        dcnt_nx = '0;
                        drop_nx = 1'b1;
                    end else begin
                        state_nx   = BEAT;
                        beat_start = 1'b1;
                        dcnt_nx    = dcnt + 4'd1;
                    end
                end
            end
            BEAT: begin
                tmr_clr = 1'b1;
                if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                    state_nx = REFRACT;
                end
            end
            REFRACT: begin
                term = RATE_W'(REFRACT_TICKS);
                if (tmr_done) begin
                    state_nx = FILL;
                    tmr_clr  = 1'b1;
                end
            end
            default: begin
                state_nx = FILL;
                tmr_clr  = 1'b1;
            end
        endcase
        if (!drop_en) begin
            dcnt_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            pace_q     <= 1'b0;
            dcnt       <= '0;
            pcnt       <= '0;
            beat_out   <= 1'b0;
            capture    <= 1'b0;
            dropped    <= 1'b0;
            beat_count <= '0;
            pace_count <= '0;
        end else begin
            state    <= state_nx;
            pace_q   <= pace_in;
            dcnt     <= dcnt_nx;
            pcnt     <= (state == BEAT) ? pcnt + PW'(1) : '0;
            beat_out <= (state_nx == BEAT);
            capture  <= cap_nx;
            dropped  <= drop_nx;
            if (beat_start) begin
                beat_count <= beat_count + COUNT_W'(1);
            end
            if (cap_nx) begin
                pace_count <= pace_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_heart_emulator.sv
// Scoreboard bench for heart_emulator: directed scenarios push expected
// beat/capture/drop events; a negedge monitor pops and compares them.
module tb_heart_emulator;

    localparam int PULSE  = 4;
    localparam int K_BEAT = 0;
    localparam int K_CAP  = 1;
    localparam int K_DROP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] interval = 8'd10;
    logic       drop_en = 1'b0;
    logic [3:0] drop_every = 4'd0;
    logic       pace_in = 1'b0;
    logic       beat_out, capture, dropped;
    logic [7:0] beat_count, pace_count;

    typedef struct {
        int kind;
        int tk;
        int al;
        int bc;
        int pc;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   tick_cnt = 0;
    int   ph = 0;
    bit   tick_en = 1'b0;
    logic tick_d = 1'b0;
    int   mon_len = 0;
    logic mon_prev = 1'b0;

    heart_emulator #(
        .RATE_W        (8),
        .PULSE_CYCLES  (PULSE),
        .REFRACT_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .interval   (interval),
        .drop_en    (drop_en),
        .drop_every (drop_every),
        .pace_in    (pace_in),
        .beat_out   (beat_out),
        .capture    (capture),
        .dropped    (dropped),
        .beat_count (beat_count),
        .pace_count (pace_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_d <= tick;

    // One tick every 4 clocks; tick_cnt numbers the ticks since scenario start.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                ph   = (ph + 1) % 4;
                tick = (ph == 0);
                if (ph == 0) tick_cnt++;
            end else begin
                tick = 1'b0;
            end
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_BEAT:  return "beat";
            K_CAP:   return "capture";
            default: return "dropped";
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int tk, input int al, input int bc, input int pc);
        ev_t e;
        e.kind = k;
        e.tk   = tk;
        e.al   = al;
        e.bc   = bc;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got %s tick=%0d bc=%0d pc=%0d expected none",
                     kname(k), tick_cnt, beat_count, pace_count);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.tk != tick_cnt || e.al != int'(tick_d) ||
                e.bc != int'(beat_count) || e.pc != int'(pace_count)) begin
                failures++;
                $display("FAIL event got %s tick=%0d aligned=%0d bc=%0d pc=%0d expected %s tick=%0d aligned=%0d bc=%0d pc=%0d",
                         kname(k), tick_cnt, tick_d, beat_count, pace_count,
                         kname(e.kind), e.tk, e.al, e.bc, e.pc);
            end
        end
    endtask

    // Monitor: rising beat_out, any capture/dropped cycle, and pulse width.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_len  = 0;
                mon_prev = 1'b0;
            end else begin
                if (beat_out && !mon_prev) got(K_BEAT);
                if (capture) got(K_CAP);
                if (dropped) got(K_DROP);
                if (beat_out) begin
                    mon_len++;
                end else if (mon_prev) begin
                    chk("beat_width", mon_len, PULSE);
                    mon_len = 0;
                end
                mon_prev = beat_out;
            end
        end
    end

    task automatic start_scn(input logic [7:0] iv, input logic de, input logic [3:0] den, input logic pace0);
        @(negedge clk);
        #1;
        tick_en = 1'b0;
        rst     = 1'b1;
        exp_q.delete();
        interval   = iv;
        drop_en    = de;
        drop_every = den;
        pace_in    = pace0;
        repeat (2) @(negedge clk);
        #1;
        tick_cnt = 0;
        ph       = 3;
        rst      = 1'b0;
        tick_en  = 1'b1;
    endtask

    task automatic run_until(input string nm, input int t);
        int n = 0;
        while (tick_cnt < t && n < 4 * t + 100) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk({nm, "_events_outstanding"}, exp_q.size(), 0);
    endtask

    task automatic wait_ticks(input int t);
        int n = 0;
        while (tick_cnt < t && n < 4 * t + 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_beat(input string nm, input logic level);
        int n = 0;
        while (beat_out != level && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_beat_wait"}, int'(beat_out), int'(level));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_beat_out", int'(beat_out), 0);
        chk("reset_capture", int'(capture), 0);
        chk("reset_dropped", int'(dropped), 0);
        chk("reset_beat_count", int'(beat_count), 0);
        chk("reset_pace_count", int'(pace_count), 0);

        // Free-running beats: due at tick 10, then every 14 ticks (10+3+1 lost in BEAT).
        start_scn(8'd10, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++) expect_ev(K_BEAT, 10 + 14 * (i - 1), 1, i, 0);
        run_until("A", 70);
        chk("A_beat_count", int'(beat_count), 5);

        // Dropout every 3rd due beat; a drop re-enters FILL directly.
        start_scn(8'd10, 1'b1, 4'd3, 1'b0);
        expect_ev(K_BEAT, 10, 1, 1, 0);
        expect_ev(K_BEAT, 24, 1, 2, 0);
        expect_ev(K_DROP, 38, 1, 2, 0);
        expect_ev(K_BEAT, 48, 1, 3, 0);
        expect_ev(K_BEAT, 62, 1, 4, 0);
        expect_ev(K_DROP, 76, 1, 4, 0);
        run_until("B", 80);

        // Pace 5 ticks into FILL: capture, then beat 3+10 ticks later.
        start_scn(8'd10, 1'b0, 4'd0, 1'b0);
        expect_ev(K_CAP, 5, 0, 0, 1);
        expect_ev(K_BEAT, 18, 1, 1, 1);
        wait_ticks(5);
        @(negedge clk);
        #1 pace_in = 1'b1;
        repeat (3) @(negedge clk);
        #1 pace_in = 1'b0;
        run_until("C", 22);
        chk("C_pace_count", int'(pace_count), 1);

        // Pace coincident with due tick; drop_every=0 acts as 2 and dcnt is untouched by pace.
        start_scn(8'd10, 1'b1, 4'd0, 1'b0);
        expect_ev(K_CAP, 10, 1, 0, 1);
        expect_ev(K_BEAT, 23, 1, 1, 1);
        expect_ev(K_DROP, 37, 1, 1, 1);
        expect_ev(K_BEAT, 47, 1, 2, 1);
        wait_ticks(10);
        #1 pace_in = 1'b1;
        repeat (3) @(negedge clk);
        #1 pace_in = 1'b0;
        run_until("D", 52);

        // Pace rising in BEAT and again in REFRACT is ignored.
        start_scn(8'd10, 1'b0, 4'd0, 1'b0);
        expect_ev(K_BEAT, 10, 1, 1, 0);
        expect_ev(K_BEAT, 24, 1, 2, 0);
        wait_beat("E_rise", 1'b1);
        #1 pace_in = 1'b1;
        wait_beat("E_fall", 1'b0);
        #1 pace_in = 1'b0;
        repeat (2) @(negedge clk);
        #1 pace_in = 1'b1;
        run_until("E", 28);
        chk("E_pace_count", int'(pace_count), 0);
        pace_in = 1'b0;

        // Reset in BEAT's second cycle, then interval=0 behaves as 1.
        start_scn(8'd10, 1'b0, 4'd0, 1'b0);
        expect_ev(K_BEAT, 10, 1, 1, 0);
        wait_beat("F_rise", 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("F_rst_beat_out", int'(beat_out), 0);
        chk("F_rst_beat_count", int'(beat_count), 0);
        chk("F_rst_pace_count", int'(pace_count), 0);
        chk("F_first_beat_seen", exp_q.size(), 0);
        start_scn(8'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 4; i++) expect_ev(K_BEAT, 1 + 5 * (i - 1), 1, i, 0);
        run_until("F", 18);

        // pace_in already high at reset release counts as an edge.
        start_scn(8'd2, 1'b0, 4'd0, 1'b1);
        expect_ev(K_CAP, 1, 0, 0, 1);
        expect_ev(K_BEAT, 5, 1, 1, 1);
        run_until("G", 8);
        pace_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
